// File: rtl/ring_router_pkg.sv
// Shared definitions for the bidirectional ring router input port.
// Packet field positions, direction and output-select encodings.
package ring_router_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int HOP_W_DEF  = 8;

   localparam int VC_BIT  = DATA_W_DEF - 1;
   localparam int DIR_BIT = DATA_W_DEF - 2;
   localparam int HOP_LSB = DATA_W_DEF - 8 - HOP_W_DEF;

   typedef enum logic {
      DIR_CW  = 1'b0,
      DIR_CCW = 1'b1
   } dir_t;

   typedef enum logic [1:0] {
      OUT_NONE,
      OUT_CW,
      OUT_CCW,
      OUT_PE
   } out_sel_t;

   function automatic int vc_bit(input int data_w);
      return data_w - 1;
   endfunction

   function automatic int dir_bit(input int data_w);
      return data_w - 2;
   endfunction

   // Hop field occupies [data_w-9 -: hop_w].
   function automatic int hop_lsb(input int data_w, input int hop_w);
      return data_w - 8 - hop_w;
   endfunction

endpackage

// File: rtl/ring_vc_fifo.sv
// Single virtual-channel FIFO with occupancy count.
// Pointers wrap naturally; DEPTH must be a power of two.
module ring_vc_fifo
   import ring_router_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [DATA_W-1:0]            din,
   input  logic                         pop,
   output logic [DATA_W-1:0]            head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: head is only consumed when count != 0.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ring_router_input_vc.sv
// Ring router input controller: two VC FIFOs, polarity-phased
// accept/serve, route decode and hop decrement on ring forwarding.
module ring_router_input_vc
   import ring_router_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int HOP_W  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        polarity,
   input  logic [DATA_W-1:0]           ch2in_din,
   input  logic                        ch2in_vld,
   output logic                        in2ch_rdy,
   output logic                        in2cw_req,
   output logic                        in2ccw_req,
   output logic                        in2pe_req,
   input  logic                        cw2in_gnt,
   input  logic                        ccw2in_gnt,
   input  logic                        pe2in_gnt,
   output logic [DATA_W-1:0]           in2out_dout,
   output logic [$clog2(DEPTH+1)-1:0]  vc0_cnt,
   output logic [$clog2(DEPTH+1)-1:0]  vc1_cnt,
   output logic                        err_vc
);

   localparam int VC_B  = vc_bit(DATA_W);
   localparam int DIR_B = dir_bit(DATA_W);
   localparam int HOP_L = hop_lsb(DATA_W, HOP_W);

   logic [DATA_W-1:0] head0;
   logic [DATA_W-1:0] head1;
   logic              full0;
   logic              full1;
   logic              empty0;
   logic              empty1;
   logic              push0;
   logic              push1;
   logic              pop0;
   logic              pop1;

   logic              take;
   logic              vc_ok;
   logic              push_a;
   logic              drop;

   logic [DATA_W-1:0] head_s;
   logic              empty_s;
   logic [HOP_W-1:0]  hop;
   dir_t              dir;
   out_sel_t          sel;
   logic              pop_s;
   logic [DATA_W-1:0] fwd;

   ring_vc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_vc0 (
      .clk   (clk),
      .rst   (rst),
      .push  (push0),
      .din   (ch2in_din),
      .pop   (pop0),
      .head  (head0),
      .count (vc0_cnt),
      .full  (full0),
      .empty (empty0)
   );

   ring_vc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_vc1 (
      .clk   (clk),
      .rst   (rst),
      .push  (push1),
      .din   (ch2in_din),
      .pop   (pop1),
      .head  (head1),
      .count (vc1_cnt),
      .full  (full1),
      .empty (empty1)
   );

   // Accept side: polarity picks the VC; a wrong-VC packet is dropped.
   assign in2ch_rdy = polarity ? ~full1 : ~full0;
   assign take      = ch2in_vld & in2ch_rdy;
   assign vc_ok     = (ch2in_din[VC_B] == polarity);
   assign push_a    = take & vc_ok;
   assign drop      = take & ~vc_ok;
   assign push0     = push_a & ~polarity;
   assign push1     = push_a & polarity;

   // Serve side is always the opposite VC.
   assign head_s  = polarity ? head0 : head1;
   assign empty_s = polarity ? empty0 : empty1;
   assign hop     = head_s[HOP_L +: HOP_W];
   assign dir     = dir_t'(head_s[DIR_B]);

   always_comb begin
      sel = OUT_NONE;
      unique case (1'b1)
         empty_s:                                  sel = OUT_NONE;
         (!empty_s && hop == '0):                  sel = OUT_PE;
         (!empty_s && hop != '0 && dir == DIR_CW):  sel = OUT_CW;
         (!empty_s && hop != '0 && dir == DIR_CCW): sel = OUT_CCW;
         default:                                  sel = OUT_NONE;
      endcase
   end

   assign in2cw_req  = (sel == OUT_CW);
   assign in2ccw_req = (sel == OUT_CCW);
   assign in2pe_req  = (sel == OUT_PE);

   assign pop_s = (in2cw_req & cw2in_gnt)
                | (in2ccw_req & ccw2in_gnt)
                | (in2pe_req & pe2in_gnt);
   assign pop0  = pop_s & polarity;
   assign pop1  = pop_s & ~polarity;

   always_comb begin
      fwd = head_s;
      fwd[HOP_L +: HOP_W] = hop - HOP_W'(1);
   end

   always_comb begin
      in2out_dout = '0;
      if (pop_s) begin
         in2out_dout = (sel == OUT_PE) ? head_s : fwd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) err_vc <= 1'b0;
      else     err_vc <= drop;
   end

endmodule
